// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX->MEM pipeline register with a valid/ready handshake and a 2-entry skid
// buffer. MEM backpressure stalls EX without inserting a bubble, and the stage sustains one
// beat per cycle. ex_ready depends only on state flops and rst, so there is no combinational
// path from mem_ready back to EX.
//
// Optional feature: define EX_MEM_HILO_EN to carry hi/lo results (whilo, hi, lo) alongside
// wdata through both entries.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-low reset
//   flush         synchronous flush, highest priority; empties both entries
//   ex_valid      EX beat valid        ex_ready   stage can accept a beat
//   ex_wdata/wd/wreg                   result data, destination register, write enable
//   ex_whilo/hi/lo                     hi/lo write enable and data (EX_MEM_HILO_EN only)
//   mem_valid     beat presented       mem_ready  MEM consumes the beat
//   mem_wdata/wd/wreg                  payload to MEM (NOP when mem_valid=0)
//   mem_whilo/hi/lo                    hi/lo payload to MEM (EX_MEM_HILO_EN only)
//   stall_cnt     saturating count of cycles with mem_valid=1 and mem_ready=0

`ifndef NOPRegAddr
`define NOPRegAddr 5'b00000
`endif
`ifndef WriteDisable
`define WriteDisable 1'b0
`endif

module ex_mem_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [ADDR_W-1:0] ex_wd,
  input  logic              ex_wreg,
`ifdef EX_MEM_HILO_EN
  input  logic              ex_whilo,
  input  logic [DATA_W-1:0] ex_hi,
  input  logic [DATA_W-1:0] ex_lo,
  output logic              mem_whilo,
  output logic [DATA_W-1:0] mem_hi,
  output logic [DATA_W-1:0] mem_lo,
`endif
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] mem_wd,
  output logic              mem_wreg,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Payload layout, MSB first: [{whilo, hi, lo},] wdata, wd, wreg
`ifdef EX_MEM_HILO_EN
  localparam int unsigned PW = 3 * DATA_W + ADDR_W + 2;
`else
  localparam int unsigned PW = DATA_W + ADDR_W + 1;
`endif

  // Empty entry reads as a NOP so a MEM stage that ignores mem_valid does nothing.
  localparam logic [PW-1:0] EmptyPay = {{(PW - ADDR_W - 1){1'b0}},
                                        ADDR_W'(`NOPRegAddr), `WriteDisable};

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e          state_q;
  logic [PW-1:0]   main_q;
  logic [PW-1:0]   skid_q;
  logic [PW-1:0]   in_pay;
  logic [CNT_W-1:0] stall_q;
  logic            accept;
  logic            deliver;

`ifdef EX_MEM_HILO_EN
  assign in_pay = {ex_whilo, ex_hi, ex_lo, ex_wdata, ex_wd, ex_wreg};
  assign {mem_whilo, mem_hi, mem_lo, mem_wdata, mem_wd, mem_wreg} = main_q;
`else
  assign in_pay = {ex_wdata, ex_wd, ex_wreg};
  assign {mem_wdata, mem_wd, mem_wreg} = main_q;
`endif

  assign mem_valid = (state_q != StEmpty);
  assign ex_ready  = rst & (state_q != StFull);
  assign accept    = ex_valid & ex_ready;
  assign deliver   = mem_valid & mem_ready;
  assign stall_cnt = stall_q;

  // main_q always drives mem_*; it is reloaded with EmptyPay whenever the stage drains so
  // the outputs need no extra muxing on mem_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StEmpty;
      main_q  <= EmptyPay;
      skid_q  <= EmptyPay;
    end else if (flush) begin
      state_q <= StEmpty;
      main_q  <= EmptyPay;
      skid_q  <= EmptyPay;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_q <= StOne;
            main_q  <= in_pay;
          end
        end
        StOne: begin
          if (accept && !deliver) begin
            state_q <= StFull;
            skid_q  <= in_pay;
          end else if (accept && deliver) begin
            main_q  <= in_pay;
          end else if (deliver) begin
            state_q <= StEmpty;
            main_q  <= EmptyPay;
          end
        end
        StFull: begin
          // ex_ready is low here, so the only event is MEM draining the main entry.
          if (deliver) begin
            state_q <= StOne;
            main_q  <= skid_q;
            skid_q  <= EmptyPay;
          end
        end
        default: begin
          state_q <= StEmpty;
          main_q  <= EmptyPay;
          skid_q  <= EmptyPay;
        end
      endcase
    end
  end

  // Stall counter survives flush; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (mem_valid && !mem_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_mem_pipe.sv
module tb_ex_mem_pipe;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          ex_valid;
  logic          ex_ready;
  logic [DW-1:0] ex_wdata;
  logic [AW-1:0] ex_wd;
  logic          ex_wreg;
  logic          mem_valid;
  logic          mem_ready;
  logic [DW-1:0] mem_wdata;
  logic [AW-1:0] mem_wd;
  logic          mem_wreg;
  logic [CW-1:0] stall_cnt;
`ifdef EX_MEM_HILO_EN
  logic          ex_whilo;
  logic [DW-1:0] ex_hi;
  logic [DW-1:0] ex_lo;
  logic          mem_whilo;
  logic [DW-1:0] mem_hi;
  logic [DW-1:0] mem_lo;
`endif

  int n_checks = 0;
  int n_err    = 0;

  ex_mem_pipe #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_wdata  (ex_wdata),
    .ex_wd     (ex_wd),
    .ex_wreg   (ex_wreg),
`ifdef EX_MEM_HILO_EN
    .ex_whilo  (ex_whilo),
    .ex_hi     (ex_hi),
    .ex_lo     (ex_lo),
    .mem_whilo (mem_whilo),
    .mem_hi    (mem_hi),
    .mem_lo    (mem_lo),
`endif
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_wdata (mem_wdata),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          fl;
    logic          v;
    logic [DW-1:0] d;
    logic [AW-1:0] wd;
    logic          wr;
    logic          mr;
    logic          e_mv;
    logic          e_er;
    logic [DW-1:0] e_d;
    logic [AW-1:0] e_wd;
    logic          e_wr;
    logic [CW-1:0] e_sc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic fl, input logic v, input logic [DW-1:0] d,
                              input logic [AW-1:0] wd, input logic wr, input logic mr,
                              input logic e_mv, input logic e_er, input logic [DW-1:0] e_d,
                              input logic [AW-1:0] e_wd, input logic e_wr,
                              input logic [CW-1:0] e_sc);
    vec_t r;
    r.fl = fl; r.v = v; r.d = d; r.wd = wd; r.wr = wr; r.mr = mr;
    r.e_mv = e_mv; r.e_er = e_er; r.e_d = e_d; r.e_wd = e_wd; r.e_wr = e_wr; r.e_sc = e_sc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fl, input logic v, input logic [DW-1:0] d,
                       input logic [AW-1:0] wd, input logic wr, input logic mr);
    flush = fl; ex_valid = v; ex_wdata = d; ex_wd = wd; ex_wreg = wr; mem_ready = mr;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b1, 32'h5A, 5'd1, 1'b1, 1'b0);
`ifdef EX_MEM_HILO_EN
    ex_whilo = 1'b0; ex_hi = '0; ex_lo = '0;
`endif

    // Reset held with ex_valid=1: nothing accepted, stage reads as NOP.
    step();
    step();
    chk("rst.mem_valid", 64'(mem_valid), 64'd0);
    chk("rst.mem_wd",    64'(mem_wd),    64'd0);
    chk("rst.mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst.ex_ready",  64'(ex_ready),  64'd0);
    chk("rst.stall_cnt", 64'(stall_cnt), 64'd0);
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    chk("rel.ex_ready", 64'(ex_ready), 64'd1);

    // Streaming 1..8 with mem_ready=1, then backpressure, then flush cases.
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(0, 1, DW'(k), 5'd3, 1, 1,  1, 1, DW'(k), 5'd3, 1, 4'd0));
    vecs.push_back(mk(0, 0, 32'h0,  5'd0, 0, 1,  0, 1, 32'h0,  5'd0, 0, 4'd0));
    vecs.push_back(mk(0, 1, 32'h11, 5'd4, 1, 0,  1, 1, 32'h11, 5'd4, 1, 4'd0));
    vecs.push_back(mk(0, 1, 32'h22, 5'd5, 0, 0,  1, 0, 32'h11, 5'd4, 1, 4'd1));
    vecs.push_back(mk(0, 1, 32'h99, 5'd6, 1, 0,  1, 0, 32'h11, 5'd4, 1, 4'd2));
    vecs.push_back(mk(0, 0, 32'h0,  5'd0, 0, 0,  1, 0, 32'h11, 5'd4, 1, 4'd3));
    vecs.push_back(mk(0, 0, 32'h0,  5'd0, 0, 1,  1, 1, 32'h22, 5'd5, 0, 4'd3));
    vecs.push_back(mk(0, 0, 32'h0,  5'd0, 0, 1,  0, 1, 32'h0,  5'd0, 0, 4'd3));
    vecs.push_back(mk(0, 1, 32'h44, 5'd6, 1, 0,  1, 1, 32'h44, 5'd6, 1, 4'd3));
    vecs.push_back(mk(0, 1, 32'h55, 5'd7, 1, 0,  1, 0, 32'h44, 5'd6, 1, 4'd4));
    vecs.push_back(mk(1, 1, 32'h33, 5'd8, 1, 0,  0, 1, 32'h0,  5'd0, 0, 4'd5));
    vecs.push_back(mk(0, 0, 32'h0,  5'd0, 0, 1,  0, 1, 32'h0,  5'd0, 0, 4'd5));
    vecs.push_back(mk(0, 1, 32'h66, 5'd9, 1, 0,  1, 1, 32'h66, 5'd9, 1, 4'd5));
    vecs.push_back(mk(0, 0, 32'h0,  5'd0, 0, 1,  0, 1, 32'h0,  5'd0, 0, 4'd5));
    vecs.push_back(mk(0, 1, 32'h77, 5'd10, 1, 1, 1, 1, 32'h77, 5'd10, 1, 4'd5));
    vecs.push_back(mk(1, 1, 32'h88, 5'd11, 1, 1, 0, 1, 32'h0,  5'd0, 0, 4'd5));
    vecs.push_back(mk(0, 0, 32'h0,  5'd0, 0, 1,  0, 1, 32'h0,  5'd0, 0, 4'd5));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].fl, vecs[i].v, vecs[i].d, vecs[i].wd, vecs[i].wr, vecs[i].mr);
      step();
      chk($sformatf("row%0d.mem_valid", i), 64'(mem_valid), 64'(vecs[i].e_mv));
      chk($sformatf("row%0d.ex_ready", i),  64'(ex_ready),  64'(vecs[i].e_er));
      chk($sformatf("row%0d.mem_wdata", i), 64'(mem_wdata), 64'(vecs[i].e_d));
      chk($sformatf("row%0d.mem_wd", i),    64'(mem_wd),    64'(vecs[i].e_wd));
      chk($sformatf("row%0d.mem_wreg", i),  64'(mem_wreg),  64'(vecs[i].e_wr));
      chk($sformatf("row%0d.stall_cnt", i), 64'(stall_cnt), 64'(vecs[i].e_sc));
    end

    // Asynchronous reset while FULL discards both beats without a clock edge.
    drive(1'b0, 1'b1, 32'hC1, 5'd12, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b1, 32'hC2, 5'd13, 1'b1, 1'b0);
    step();
    chk("full.ex_ready", 64'(ex_ready), 64'd0);
    #2 rst = 1'b0;
    #1;
    chk("arst.mem_valid", 64'(mem_valid), 64'd0);
    chk("arst.mem_wdata", 64'(mem_wdata), 64'd0);
    chk("arst.ex_ready",  64'(ex_ready),  64'd0);
    chk("arst.stall_cnt", 64'(stall_cnt), 64'd0);
    step();
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    step();
    chk("arst.after.mem_valid", 64'(mem_valid), 64'd0);
    chk("arst.after.mem_wdata", 64'(mem_wdata), 64'd0);

    // Saturation: one beat stalled for 20 cycles on a 4-bit counter.
    drive(1'b0, 1'b1, 32'hAB, 5'd2, 1'b1, 1'b0);
`ifdef EX_MEM_HILO_EN
    ex_whilo = 1'b1; ex_hi = 32'hDEAD; ex_lo = 32'hBEEF;
`endif
    step();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
`ifdef EX_MEM_HILO_EN
    ex_whilo = 1'b0; ex_hi = '0; ex_lo = '0;
    chk("hilo.mem_whilo", 64'(mem_whilo), 64'd1);
    chk("hilo.mem_hi",    64'(mem_hi),    64'hDEAD);
    chk("hilo.mem_lo",    64'(mem_lo),    64'hBEEF);
`endif
    chk("sat.mem_wdata0", 64'(mem_wdata), 64'hAB);
    repeat (14) step();
    chk("sat.cnt14", 64'(stall_cnt), 64'd14);
    repeat (6) step();
    chk("sat.cnt20", 64'(stall_cnt), 64'd15);
    chk("sat.hold_wdata", 64'(mem_wdata), 64'hAB);
    mem_ready = 1'b1;
    step();
    chk("sat.drain.mem_valid", 64'(mem_valid), 64'd0);
    chk("sat.drain.stall_cnt", 64'(stall_cnt), 64'd15);
`ifdef EX_MEM_HILO_EN
    chk("sat.drain.mem_hi", 64'(mem_hi), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
